pspin_hostmem_dma_wr: RTL
=========================

PSPIN_HOSTMEM_DMA_WR -- requirements
Module: pspin_hostmem_dma_wr

Interface
REQ-001 Params: ADDR_WIDTH 64 host address; DATA_WIDTH 512 AXI data; STRB_WIDTH DATA_WIDTH/8; ID_WIDTH 8 AXI ID.
REQ-002 Params: DMA_LEN_WIDTH 16; DMA_TAG_WIDTH 16; DMA_IMM_WIDTH 32; RAM_SEL_WIDTH 4; RAM_ADDR_WIDTH 20.
REQ-003 Params: RAM_SEG_COUNT 2; RAM_SEG_DATA_WIDTH DATA_WIDTH/RAM_SEG_COUNT; RAM_SEG_BE_WIDTH RAM_SEG_DATA_WIDTH/8; RAM_SEG_ADDR_WIDTH RAM_ADDR_WIDTH-$clog2(STRB_WIDTH).
REQ-004 Param: STATUS_TIMEOUT 65535, status watchdog limit in cycles.
REQ-005 One clock, clk; reset rstn, synchronous, active-low.
REQ-006 Write descriptor outputs: dma_addr ADDR_WIDTH, ram_sel RAM_SEL_WIDTH, ram_addr RAM_ADDR_WIDTH, imm DMA_IMM_WIDTH, imm_en 1, len DMA_LEN_WIDTH, tag DMA_TAG_WIDTH, valid 1. Input: ready 1. All prefixed m_axis_write_desc_.
REQ-007 Status inputs s_axis_write_desc_status_: tag DMA_TAG_WIDTH, error 4, valid 1.
REQ-008 RAM write port: ram_wr_cmd_be out SEG_COUNT*SEG_BE; ram_wr_cmd_addr out SEG_COUNT*SEG_ADDR; ram_wr_cmd_data out SEG_COUNT*SEG_DATA; ram_wr_cmd_valid out SEG_COUNT; ram_wr_cmd_ready in SEG_COUNT; ram_wr_done in SEG_COUNT.
REQ-009 AXI AW inputs: s_axi_awid, awaddr, awlen[7:0], awsize[2:0], awburst[1:0], awvalid. Output: awready.
REQ-010 AXI W inputs: s_axi_wdata, wstrb, wlast, wvalid. Output: wready.
REQ-011 AXI B outputs: s_axi_bid, bresp[1:0], bvalid. Input: bready. Sideband inputs awlock/awcache/awprot/awqos/awregion/awuser/wuser are accepted and ignored. Output buser is tied 0.

Function
REQ-012 One burst is in flight at a time. FSM: IDLE -> DATA -> DRAIN -> DESC -> STATUS -> RESP -> IDLE.
REQ-013 IDLE: awready=1. On AW handshake, latch id/addr/len/size/burst; go to DATA.
REQ-014 The burst is legal iff awburst==INCR and awsize==$clog2(STRB_WIDTH), and (awlen+1)*STRB_WIDTH fits in both RAM_ADDR_WIDTH and DMA_LEN_WIDTH. An illegal burst sets err, drains W with no RAM writes, then skips to RESP with bresp=SLVERR (2'b10).
REQ-015 DATA: wready=1 only while no segment command is pending. Beat n drives every segment valid, with addr=n, data slice, and be=wstrb slice.
REQ-016 A segment's valid drops once its ready is seen. wready re-asserts only after all segments accept. Per-segment outstanding counters increment on accept and decrement on ram_wr_done; accept and done in the same cycle leave the counter unchanged.
REQ-017 Beat count is enforced by awlen, not wlast. A wlast mismatch sets err, and the burst still consumes exactly awlen+1 beats.
REQ-018 DRAIN: wait until all outstanding counters reach 0.
REQ-019 DESC: drive valid with dma_addr=awaddr, ram_addr=awaddr[$clog2(STRB_WIDTH)-1:0], len=(awlen+1)*STRB_WIDTH-ram_addr, ram_sel=0, imm=0, imm_en=0, tag=tag counter. Hold until ready.
REQ-020 The tag counter increments after each descriptor handshake and wraps modulo 2^DMA_TAG_WIDTH.
REQ-021 STATUS: wait for status valid with a matching tag; non-matching statuses are ignored. error!=0 -> SLVERR, else OKAY unless err is set.
REQ-022 RESP: bvalid=1 and bid=latched id, held stable until bready; then return to IDLE. Back-to-back bursts therefore incur at least 1 idle cycle.

Reset
REQ-023 With rstn low at a clock edge: FSM=IDLE, counters=0, tag=0, err=0, and all valid/ready outputs 0 except awready, which becomes 1 on the first cycle after reset.
REQ-024 Reset mid-burst abandons the burst without generating a B response. A stale status arriving after reset is ignored.

Configuration
REQ-025 Macro PSPIN_HOSTMEM_DMA_WR_TIMEOUT_EN defined: a STATUS-state cycle counter runs, and reaching STATUS_TIMEOUT forces RESP with bresp=SLVERR. A late status for that tag is ignored.
REQ-026 Macro undefined: no counter; STATUS waits indefinitely.

Verification
REQ-027 awaddr=0x1000, awlen=3, full strobes -> 4 beats at RAM addrs 0..3; descriptor len=256, ram_addr=0, tag=0; status error 0 -> bresp=OKAY, bid echoed.
REQ-028 awaddr=0x2010, awlen=0 -> descriptor ram_addr=0x10, len=48.
REQ-029 awsize=2 -> no RAM writes, no descriptor, W drained, bresp=SLVERR.
REQ-030 ram_wr_cmd_ready held low on segment 1 for 5 cycles -> wready stays low for those 5 cycles; ram_wr_done delayed 10 cycles -> descriptor is not issued until done.
REQ-031 Status with wrong tag, then correct tag with error=1 -> wrong tag ignored, then bresp=SLVERR.
REQ-032 With TIMEOUT_EN and STATUS_TIMEOUT=16, no status -> bresp=SLVERR after 16 cycles; a status delivered afterwards has no effect.

Source files
------------

// File: rtl/pspin_hostmem_dma_wr_if.sv
// AXI4 write-channel bundle (AW/W/B) between a host-side master and the DMA write bridge.
interface pspin_hostmem_dma_wr_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 8
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic [3:0]            awqos;
  logic [3:0]            awregion;
  logic                  awuser;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wuser;
  logic                  wvalid;
  logic                  wready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  buser;
  logic                  bvalid;
  logic                  bready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input  bready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bid, bresp, buser, bvalid,
    output bready
  );
endinterface

// File: rtl/pspin_hostmem_dma_wr.sv
// AXI write slave -> segmented RAM writes -> one DMA write descriptor per burst -> B response.
// Optional status watchdog enabled by defining PSPIN_HOSTMEM_DMA_WR_TIMEOUT_EN.
module pspin_hostmem_dma_wr #(
  parameter int ADDR_WIDTH         = 64,
  parameter int DATA_WIDTH         = 512,
  parameter int STRB_WIDTH         = DATA_WIDTH / 8,
  parameter int ID_WIDTH           = 8,
  parameter int DMA_LEN_WIDTH      = 16,
  parameter int DMA_TAG_WIDTH      = 16,
  parameter int DMA_IMM_WIDTH      = 32,
  parameter int RAM_SEL_WIDTH      = 4,
  parameter int RAM_ADDR_WIDTH     = 20,
  parameter int RAM_SEG_COUNT      = 2,
  parameter int RAM_SEG_DATA_WIDTH = DATA_WIDTH / RAM_SEG_COUNT,
  parameter int RAM_SEG_BE_WIDTH   = RAM_SEG_DATA_WIDTH / 8,
  parameter int RAM_SEG_ADDR_WIDTH = RAM_ADDR_WIDTH - $clog2(STRB_WIDTH),
  parameter int STATUS_TIMEOUT     = 65535
) (
  input  logic                                         clk,
  input  logic                                         rstn,
  pspin_hostmem_dma_wr_if.slave                        s_axi,
  output logic [ADDR_WIDTH-1:0]                        m_axis_write_desc_dma_addr,
  output logic [RAM_SEL_WIDTH-1:0]                     m_axis_write_desc_ram_sel,
  output logic [RAM_ADDR_WIDTH-1:0]                    m_axis_write_desc_ram_addr,
  output logic [DMA_IMM_WIDTH-1:0]                     m_axis_write_desc_imm,
  output logic                                         m_axis_write_desc_imm_en,
  output logic [DMA_LEN_WIDTH-1:0]                     m_axis_write_desc_len,
  output logic [DMA_TAG_WIDTH-1:0]                     m_axis_write_desc_tag,
  output logic                                         m_axis_write_desc_valid,
  input  logic                                         m_axis_write_desc_ready,
  input  logic [DMA_TAG_WIDTH-1:0]                     s_axis_write_desc_status_tag,
  input  logic [3:0]                                   s_axis_write_desc_status_error,
  input  logic                                         s_axis_write_desc_status_valid,
  output logic [RAM_SEG_COUNT*RAM_SEG_BE_WIDTH-1:0]    ram_wr_cmd_be,
  output logic [RAM_SEG_COUNT*RAM_SEG_ADDR_WIDTH-1:0]  ram_wr_cmd_addr,
  output logic [RAM_SEG_COUNT*RAM_SEG_DATA_WIDTH-1:0]  ram_wr_cmd_data,
  output logic [RAM_SEG_COUNT-1:0]                     ram_wr_cmd_valid,
  input  logic [RAM_SEG_COUNT-1:0]                     ram_wr_cmd_ready,
  input  logic [RAM_SEG_COUNT-1:0]                     ram_wr_done
);
  localparam int OFFS_W = $clog2(STRB_WIDTH);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, DATA, DRAIN, DESC, STATUS, RESP} state_t;
  state_t state, state_nxt;

  logic [ID_WIDTH-1:0]                   id_q;
  logic [ADDR_WIDTH-1:0]                 addr_q;
  logic [7:0]                            len_q, beat_q;
  logic                                  illegal_q, err_q;
  logic [1:0]                            bresp_q, bresp_nxt;
  logic [RAM_SEG_COUNT-1:0]              pend_q;
  logic [RAM_SEG_COUNT-1:0][8:0]         outst_q;
  logic [RAM_SEG_ADDR_WIDTH-1:0]         seg_addr_q;
  logic [DATA_WIDTH-1:0]                 data_q;
  logic [STRB_WIDTH-1:0]                 be_q;
  logic [DMA_TAG_WIDTH-1:0]              tag_q, stat_tag_q;
  logic [31:0]                           aw_bytes, bytes;
  logic aw_legal, w_hs, last, drained, stat_hit;

  // Sideband fields carry nothing this bridge acts on.
  logic unused_sideband;
  assign unused_sideband = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos,
                             s_axi.awregion, s_axi.awuser, s_axi.wuser};

  assign aw_bytes = (32'(s_axi.awlen) + 32'd1) << OFFS_W;
  assign aw_legal = (s_axi.awburst == 2'b01) && (s_axi.awsize == 3'(OFFS_W)) &&
                    ((aw_bytes >> RAM_ADDR_WIDTH) == 32'd0) && ((aw_bytes >> DMA_LEN_WIDTH) == 32'd0);
  assign bytes    = (32'(len_q) + 32'd1) << OFFS_W;

  assign s_axi.awready = (state == IDLE) && rstn;
  assign s_axi.wready  = (state == DATA) && (pend_q == '0);
  assign w_hs          = s_axi.wvalid && s_axi.wready;
  assign last          = (beat_q == len_q);
  assign stat_hit      = s_axis_write_desc_status_valid && (s_axis_write_desc_status_tag == stat_tag_q);

  assign s_axi.bvalid  = (state == RESP);
  assign s_axi.bid     = id_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.buser   = 1'b0;

  assign m_axis_write_desc_valid    = (state == DESC);
  assign m_axis_write_desc_dma_addr = addr_q;
  assign m_axis_write_desc_ram_addr = RAM_ADDR_WIDTH'(addr_q[OFFS_W-1:0]);
  assign m_axis_write_desc_len      = DMA_LEN_WIDTH'(bytes - 32'(addr_q[OFFS_W-1:0]));
  assign m_axis_write_desc_tag      = tag_q;
  assign m_axis_write_desc_ram_sel  = '0;
  assign m_axis_write_desc_imm      = '0;
  assign m_axis_write_desc_imm_en   = 1'b0;

  assign ram_wr_cmd_valid = pend_q;
  assign ram_wr_cmd_data  = data_q;
  assign ram_wr_cmd_be    = be_q;
  assign ram_wr_cmd_addr  = {RAM_SEG_COUNT{seg_addr_q}};

  always_comb begin
    drained = (pend_q == '0);
    for (int i = 0; i < RAM_SEG_COUNT; i++)
      if (outst_q[i] != '0) drained = 1'b0;
  end

`ifdef PSPIN_HOSTMEM_DMA_WR_TIMEOUT_EN
  logic [31:0] tmo_q;
  always_ff @(posedge clk) begin
    if (!rstn || state != STATUS) tmo_q <= '0;
    else                          tmo_q <= tmo_q + 32'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      bresp_q <= OKAY;
    end else begin
      state   <= state_nxt;
      bresp_q <= bresp_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bresp_nxt = bresp_q;
    case (state)
      IDLE:   if (s_axi.awvalid) state_nxt = DATA;
      DATA:   if (w_hs && last) begin
                if (illegal_q) begin state_nxt = RESP; bresp_nxt = SLVERR; end
                else           state_nxt = DRAIN;
              end
      DRAIN:  if (drained) state_nxt = DESC;
      DESC:   if (m_axis_write_desc_ready) state_nxt = STATUS;
      STATUS: begin
                if (stat_hit) begin
                  state_nxt = RESP;
                  bresp_nxt = (s_axis_write_desc_status_error != 4'd0 || err_q) ? SLVERR : OKAY;
                end
`ifdef PSPIN_HOSTMEM_DMA_WR_TIMEOUT_EN
                else if (tmo_q == 32'(STATUS_TIMEOUT - 1)) begin
                  state_nxt = RESP;
                  bresp_nxt = SLVERR;
                end
`endif
              end
      RESP:   if (s_axi.bready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Burst payload and beat data need no reset: only read while the FSM says they are live.
  always_ff @(posedge clk) begin
    if (state == IDLE && s_axi.awvalid) begin
      id_q   <= s_axi.awid;
      addr_q <= s_axi.awaddr;
      len_q  <= s_axi.awlen;
    end
    if (w_hs) begin
      seg_addr_q <= RAM_SEG_ADDR_WIDTH'(beat_q);
      data_q     <= s_axi.wdata;
      be_q       <= s_axi.wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend_q     <= '0;
      outst_q    <= '0;
      beat_q     <= '0;
      illegal_q  <= 1'b0;
      err_q      <= 1'b0;
      tag_q      <= '0;
      stat_tag_q <= '0;
    end else begin
      if (state == IDLE && s_axi.awvalid) begin
        beat_q    <= '0;
        illegal_q <= !aw_legal;
        err_q     <= !aw_legal;
      end
      // Beat count follows awlen; a wlast in the wrong place only poisons the response.
      if (w_hs) begin
        beat_q <= beat_q + 8'd1;
        if (s_axi.wlast != last) err_q <= 1'b1;
        if (!illegal_q) pend_q <= '1;
      end else begin
        pend_q <= pend_q & ~ram_wr_cmd_ready;
      end
      for (int i = 0; i < RAM_SEG_COUNT; i++) begin
        case ({pend_q[i] & ram_wr_cmd_ready[i], ram_wr_done[i]})
          2'b10:   outst_q[i] <= outst_q[i] + 9'd1;
          2'b01:   if (outst_q[i] != '0) outst_q[i] <= outst_q[i] - 9'd1;
          default: ;
        endcase
      end
      if (state == DESC && m_axis_write_desc_ready) begin
        tag_q      <= tag_q + 1'b1;
        stat_tag_q <= tag_q;
      end
    end
  end
endmodule
